// File: rtl/cache_mem_responder.sv
// Behavioural main memory on the cache-to-memory bus: single-word reads and
// writes over the rd_mem/wr_mem/ready_mem handshake with a fixed access latency.
module cache_mem_responder #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH_CPU = 32,
    parameter int LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [AWIDTH-1:0]     addr_mem,
    inout  wire  [DWIDTH_CPU-1:0] data_mem,
    input  logic                  rd_mem,
    input  logic                  wr_mem,
    output logic                  ready_mem,
    output logic                  busy,
    output logic                  proto_err,
    input  logic                  pre_we,
    input  logic [AWIDTH-1:0]     pre_addr,
    input  logic [DWIDTH_CPU-1:0] pre_data
);

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("cache_mem_responder: LATENCY must be in 2..15");
    end

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [DWIDTH_CPU-1:0] mem [2**AWIDTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AWIDTH-1:0]     addr_q, addr_d;
    logic [DWIDTH_CPU-1:0] rdata_q, rdata_d;
    logic                  drive_q, drive_d;
    logic                  rd_q, wr_q;
    logic                  busy_q, busy_d;
    logic                  proto_err_q, proto_err_d;

    logic                  rd_rise, wr_rise;
    logic                  mem_we;
    logic [AWIDTH-1:0]     mem_waddr;
    logic [DWIDTH_CPU-1:0] mem_wdata;

    assign rd_rise = rd_mem & ~rd_q;
    assign wr_rise = wr_mem & ~wr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            drive_q     <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            drive_q     <= drive_d;
            rd_q        <= rd_mem;
            wr_q        <= wr_mem;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage is never cleared; reset only blocks a write that would land this edge.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        drive_d     = drive_q;
        mem_we      = 1'b0;
        mem_waddr   = pre_addr;
        mem_wdata   = pre_data;
        proto_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_rise && wr_rise) begin
                    proto_err_d = 1'b1;
                    mem_we      = pre_we;
                end else if (rd_rise) begin
                    state_d = RD_BUSY;
                    cnt_d   = CNT_INIT;
                    addr_d  = addr_mem;
                    drive_d = 1'b0;
                end else if (wr_rise) begin
                    state_d = WR_BUSY;
                    cnt_d   = CNT_INIT;
                    addr_d  = addr_mem;
                    drive_d = 1'b0;
                end else begin
                    mem_we = pre_we;
                end
            end
            RD_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    rdata_d = mem[addr_q];
                    drive_d = 1'b1;
                end
            end
            WR_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // Write data arrives after the request, so it is sampled only now.
                if (cnt_q <= 4'd1) begin
                    state_d   = IDLE;
                    mem_we    = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = data_mem;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        ready_mem = (state_q == IDLE) & ~rd_rise & ~wr_rise;
        busy      = busy_q;
        proto_err = proto_err_q;
    end

    // A rising wr_mem always wins the bus, so the cache never sees contention.
    assign data_mem = (drive_q && !wr_mem) ? rdata_q : 'z;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: read/write latency, read-drive
// window, held and illegal requests, reset abort and preload gating.
module tb_cache_mem_responder;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LAT = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW-1:0] addr_mem;
  wire  [DW-1:0] data_mem;
  logic          rd_mem, wr_mem;
  logic          ready_mem, busy, proto_err;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic          tb_drv;
  logic [DW-1:0] tb_wdata;

  // Released bus reads back as zero.
  assign data_mem = tb_drv ? tb_wdata : 'z;
  for (genvar gi = 0; gi < DW; gi++) begin : g_pd
    pulldown (data_mem[gi]);
  end

  cache_mem_responder #(.AWIDTH(AW), .DWIDTH_CPU(DW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .addr_mem(addr_mem), .data_mem(data_mem),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .ready_mem(ready_mem), .busy(busy),
    .proto_err(proto_err), .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [0:(1<<AW)-1];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick();
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
    model[a] = d;
  endtask

  // Counts cycles ready_mem stays low, starting from the given count.
  task automatic wait_ready(input int start, output int lows);
    bit done = 1'b0;
    lows = start;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (ready_mem) begin
        done = 1'b1;
        break;
      end
      lows++;
    end
    if (!done) check("ready_timeout", {31'd0, ready_mem}, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input bit busy_pre);
    int lows;
    logic [DW-1:0] got_exp;
    exp_q.push_back(model[a]);
    tick();
    addr_mem = a; rd_mem = 1'b1;
    @(negedge clock);
    check("rd_rise_ready", {31'd0, ready_mem}, 32'd0);
    if (busy_pre) begin
      tick();
      pre_we = 1'b1; pre_addr = a; pre_data = ~model[a];
      tick();
      pre_we = 1'b0;
      wait_ready(2, lows);
    end else begin
      wait_ready(1, lows);
    end
    check("rd_latency", lows, LAT);
    got_exp = exp_q.pop_front();
    check("rd_data", data_mem, got_exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_busy", {31'd0, busy}, 32'd0);
      check("hold_ready", {31'd0, ready_mem}, 32'd1);
      check("hold_data", data_mem, got_exp);
    end
    tick();
    rd_mem = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lows;
    tick();
    addr_mem = a; wr_mem = 1'b1;
    @(negedge clock);
    check("wr_release", data_mem, 32'd0);
    check("wr_rise_ready", {31'd0, ready_mem}, 32'd0);
    tick();
    tb_drv = 1'b1; tb_wdata = d;
    wait_ready(1, lows);
    check("wr_latency", lows, LAT);
    model[a] = d;
    tick();
    wr_mem = 1'b0; tb_drv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    reset = 1'b1; rd_mem = 1'b0; wr_mem = 1'b0; addr_mem = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; tb_drv = 1'b0; tb_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'd0, ready_mem}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    check("rst_data_released", data_mem, 32'd0);
    tick();
    reset = 1'b0;

    // read with held request, then write that must take the bus
    preload(9'h05A, 32'hDEAD_BEEF);
    do_read(9'h05A, 3, 1'b0);
    do_write(9'h1FF, 32'h1234_5678);
    do_read(9'h1FF, 0, 1'b0);

    // simultaneous rise: one-cycle error, no access, no storage change
    tick();
    addr_mem = 9'h05A; rd_mem = 1'b1; wr_mem = 1'b1; tb_drv = 1'b1; tb_wdata = 32'h5555_5555;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("err_pulse", {31'd0, proto_err}, 32'd1);
        check("err_ready", {31'd0, ready_mem}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
      end
      pulses += int'(proto_err);
    end
    check("err_pulse_width", pulses, 1);
    tick();
    rd_mem = 1'b0; wr_mem = 1'b0; tb_drv = 1'b0;
    do_read(9'h05A, 0, 1'b0);

    // reset two cycles after a write is accepted aborts it
    preload(9'h010, 32'h0);
    tick();
    addr_mem = 9'h010; wr_mem = 1'b1;
    @(negedge clock);
    check("rstw_rise_ready", {31'd0, ready_mem}, 32'd0);
    tick();
    tb_drv = 1'b1; tb_wdata = 32'hAAAA_AAAA;
    @(negedge clock);
    check("rstw_busy", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; wr_mem = 1'b0;
    @(negedge clock);
    check("rstw_ready", {31'd0, ready_mem}, 32'd1);
    check("rstw_busy_after", {31'd0, busy}, 32'd0);
    tick();
    tb_drv = 1'b0;
    do_read(9'h010, 0, 1'b0);

    // preload while RD_BUSY is ignored
    do_read(9'h05A, 0, 1'b1);
    do_read(9'h05A, 0, 1'b0);

    // random write / read-back
    for (int n = 0; n < 6; n++) begin
      ra = AW'($urandom_range(0, (1 << AW) - 1));
      rd = $urandom;
      do_write(ra, rd);
      do_read(ra, 0, 1'b0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
